lcd_phy_arb: RTL and testbench

Two-requester arbiter that shares the single LCD PHY write port (data/rs/valid/ready) between the SPI-side LCD write path (requester A) and an FPGA-local producer such as a framebuffer streamer (requester B). Arbitration happens at transfer granularity, where one transfer is a run of beats ending with `last`, so command/data framing towards the panel is never interleaved. A registered output stage drives the PHY. A watchdog reclaims the port from a stalled owner.

---
 rtl/lcd_phy_arb.sv | 80 ++++++++
 tb/tb_lcd_phy_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_phy_arb.sv
// lcd_phy_arb: two-requester, transfer-granular arbiter for the LCD PHY write port
// with a registered output stage and an owner-idle watchdog.
module lcd_phy_arb #(
  parameter bit PRIO_A = 1'b1,
  parameter int TIMEOUT = 1024,
  parameter int TW = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_data,
  input  logic       a_rs,
  input  logic       a_last,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_rs,
  input  logic       b_last,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] phy_data,
  output logic       phy_rs,
  output logic       phy_valid,
  input  logic       phy_ready,
  output logic       busy,
  output logic       owner,
  output logic       err_timeout
);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic last_b;
  logic free, a_acc, b_acc, acc_last, own_valid, tmo, pick_b;
  assign free = ~phy_valid | phy_ready;
  assign a_ready = (state == GNT_A) & free;
  assign b_ready = (state == GNT_B) & free;
  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;
  assign acc_last = (a_acc & a_last) | (b_acc & b_last);
  assign own_valid = (state == GNT_B) ? b_valid : a_valid;
  assign tmo = (TIMEOUT != 0) && (state != IDLE) && !own_valid && (cnt == TW'(TIMEOUT - 1));
  // last_b=1 means B was served last, so A is preferred on a round-robin tie
  assign pick_b = !a_valid | (b_valid & !PRIO_A & !last_b);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last_b <= 1'b1;
      phy_data <= '0;
      phy_rs <= 1'b0;
      phy_valid <= 1'b0;
      busy <= 1'b0;
      owner <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo;
      if (a_acc | b_acc) begin
        phy_valid <= 1'b1;
        phy_data <= b_acc ? b_data : a_data;
        phy_rs <= b_acc ? b_rs : a_rs;
      end else if (phy_ready) begin
        phy_valid <= 1'b0;
      end
      if (state == IDLE) begin
        cnt <= '0;
        if (a_valid | b_valid) begin
          state <= pick_b ? GNT_B : GNT_A;
          owner <= pick_b;
          busy <= 1'b1;
        end
      end else if (acc_last | tmo) begin
        state <= IDLE;
        busy <= 1'b0;
        last_b <= (state == GNT_B);
        cnt <= '0;
      end else begin
        cnt <= own_valid ? '0 : cnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lcd_phy_arb.sv
// tb_lcd_phy_arb: randomized scoreboard bench for lcd_phy_arb (round-robin/watchdog
// instance) plus a directed fixed-priority instance.
module tb_lcd_phy_arb;
  localparam int TMO = 8;
  localparam int NT = 30;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] a_data = '0, b_data = '0, phy_data;
  logic a_rs = 1'b0, a_last = 1'b0, a_valid = 1'b0, b_rs = 1'b0, b_last = 1'b0, b_valid = 1'b0;
  logic a_ready, b_ready, phy_rs, phy_valid, busy, owner, err_timeout;
  logic phy_ready = 1'b1;
  logic bp_en = 1'b0;
  logic [7:0] c_data = '0, d_data = 8'hB0, q_data;
  logic c_valid = 1'b0, d_valid = 1'b0, c_ready, d_ready, q_rs, q_valid, q_busy, q_owner, q_err;
  int checks = 0, errors = 0, err_pulses = 0;
  logic [8:0] sq[$];
  logic [9:0] q1[$];

  lcd_phy_arb #(.PRIO_A(1'b0), .TIMEOUT(TMO), .TW(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_rs(a_rs), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_rs(b_rs), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready),
    .phy_data(phy_data), .phy_rs(phy_rs), .phy_valid(phy_valid), .phy_ready(phy_ready),
    .busy(busy), .owner(owner), .err_timeout(err_timeout)
  );

  lcd_phy_arb #(.PRIO_A(1'b1), .TIMEOUT(0), .TW(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_data(c_data), .a_rs(1'b0), .a_last(1'b1), .a_valid(c_valid), .a_ready(c_ready),
    .b_data(d_data), .b_rs(1'b1), .b_last(1'b1), .b_valid(d_valid), .b_ready(d_ready),
    .phy_data(q_data), .phy_rs(q_rs), .phy_valid(q_valid), .phy_ready(1'b1),
    .busy(q_busy), .owner(q_owner), .err_timeout(q_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // present one beat {last,rs,data}, wait for its accept, then optionally idle valid
  task automatic drive(input bit is_b, input logic [9:0] w, input int gap, output int polls);
    bit acc;
    acc = 1'b0;
    polls = 0;
    if (is_b) begin {b_last, b_rs, b_data} = w; b_valid = 1'b1; end
    else begin {a_last, a_rs, a_data} = w; a_valid = 1'b1; end
    while (!acc && polls < 300) begin
      @(negedge clk);
      polls++;
      acc = is_b ? (b_valid & b_ready) : (a_valid & a_ready);
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_wait side=%0d actual=no_accept required=accept", is_b);
    end
    if (gap > 0) begin
      if (is_b) b_valid = 1'b0; else a_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  int burst = 0;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      if (burst > 0) begin phy_ready = 1'b0; burst--; end
      else if ($urandom_range(0, 15) == 0) begin phy_ready = 1'b0; burst = 4; end
      else phy_ready = ($urandom_range(0, 3) != 0);
    end
  end

  logic hold_v = 1'b0, err_prev = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v) check("phy_hold", 32'({phy_valid, phy_rs, phy_data}), 32'({1'b1, held}));
      hold_v = phy_valid & ~phy_ready;
      held = {phy_rs, phy_data};
      if (phy_valid & phy_ready) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL phy_beat actual=%0h required=no_beat", {phy_rs, phy_data});
        end else check("phy_beat", 32'({phy_rs, phy_data}), 32'(sq.pop_front()));
      end
      check("excl_ready", 32'(a_ready & b_ready), 0);
      if (phy_valid & ~phy_ready) check("bp_ready", 32'({a_ready, b_ready}), 0);
      if (err_timeout) begin
        err_pulses++;
        check("err_one_cycle", 32'(err_prev), 0);
      end
      err_prev = err_timeout;
      if (q_valid) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_beat actual=%0h required=no_beat", {q_owner, q_rs, q_data});
        end else check("u1_beat", 32'({q_owner, q_rs, q_data}), 32'(q1.pop_front()));
      end
      if (c_valid) check("u1_b_starve", 32'(d_ready), 0);
      check("u1_no_err", 32'(q_err), 0);
    end else begin
      hold_v = 1'b0;
      err_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [9:0] aw[$], bw[$];
    int ag[$], bg[$];
    int polls, n, len, e_k, b_k;
    logic [9:0] w;
    #1;
    check("rst_phy", 32'({phy_valid, phy_rs, phy_data}), 0);
    check("rst_ready", 32'({a_ready, b_ready}), 0);
    check("rst_flags", 32'({busy, owner, err_timeout}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // fixed priority: A keeps winning while it requests, B starves
    @(posedge clk); #1;
    c_data = 8'hA0; c_valid = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 4; i++) q1.push_back({1'b0, 1'b0, 8'(8'hA0 + i)});
    q1.push_back({1'b1, 1'b1, 8'hB0});
    n = 0; polls = 0;
    while (n < 4 && polls < 100) begin
      @(negedge clk); polls++;
      b_k = int'(c_ready);
      @(posedge clk); #1;
      if (b_k != 0) begin n++; c_data = c_data + 8'd1; if (n == 4) c_valid = 1'b0; end
    end
    check("u1_a_count", n, 4);
    n = 0; polls = 0;
    while (n < 1 && polls < 100) begin
      @(negedge clk); polls++;
      b_k = int'(d_ready);
      @(posedge clk); #1;
      if (b_k != 0) begin n++; d_valid = 1'b0; end
    end
    check("u1_b_count", n, 1);
    repeat (3) @(posedge clk); #1;
    check("u1_idle", 32'(q_busy), 0);
    // randomized round-robin traffic: both always backlogged, so transfers alternate A,B,...
    for (int t = 0; t < NT; t++) begin
      for (int s = 0; s < 2; s++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          w = {j == len - 1, 1'($urandom), 8'($urandom)};
          sq.push_back(w[8:0]);
          if (s == 0) begin aw.push_back(w); ag.push_back(j == len - 1 ? 0 : $urandom_range(0, TMO - 3)); end
          else begin bw.push_back(w); bg.push_back(j == len - 1 ? 0 : $urandom_range(0, TMO - 3)); end
        end
      end
    end
    bp_en = 1'b1;
    fork
      begin
        int pa;
        for (int i = 0; i < aw.size(); i++) drive(1'b0, aw[i], ag[i], pa);
        a_valid = 1'b0;
      end
      begin
        int pb;
        for (int i = 0; i < bw.size(); i++) drive(1'b1, bw[i], bg[i], pb);
        b_valid = 1'b0;
      end
    join
    bp_en = 1'b0;
    phy_ready = 1'b1;
    for (int k = 0; k < 200 && sq.size() != 0; k++) @(negedge clk);
    check("rand_drain", sq.size(), 0);
    repeat (3) @(posedge clk); #1;
    // A-only 3-beat transfer: ready one clock after valid, back-to-back beats
    sq.push_back({1'b0, 8'h2A}); sq.push_back({1'b1, 8'h00}); sq.push_back({1'b1, 8'hEF});
    {a_last, a_rs, a_data} = {1'b0, 1'b0, 8'h2A}; a_valid = 1'b1;
    @(negedge clk);
    check("a_ready_idle", 32'(a_ready), 0);
    drive(1'b0, {1'b0, 1'b0, 8'h2A}, 0, polls);
    check("a_ready_latency", polls, 1);
    drive(1'b0, {1'b0, 1'b1, 8'h00}, 0, polls);
    check("b2b_beat2", polls, 1);
    drive(1'b0, {1'b1, 1'b1, 8'hEF}, 0, polls);
    check("b2b_beat3", polls, 1);
    a_valid = 1'b0;
    @(negedge clk);
    check("busy_fall", 32'(busy), 0);
    repeat (3) @(posedge clk); #1;
    // watchdog: A stalls after one non-last beat, B waits
    sq.push_back({1'b1, 8'h11}); sq.push_back({1'b0, 8'h1B});
    drive(1'b0, {1'b0, 1'b1, 8'h11}, 0, polls);
    a_valid = 1'b0;
    {b_last, b_rs, b_data} = {1'b1, 1'b0, 8'h1B}; b_valid = 1'b1;
    e_k = 0; b_k = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (err_timeout && e_k == 0) begin e_k = k; check("tmo_idle", 32'(busy), 0); end
      if (b_ready && b_k == 0) begin b_k = k; @(posedge clk); #1 b_valid = 1'b0; end
    end
    check("tmo_cycle", e_k, TMO + 1);
    check("tmo_grant_b", b_k, TMO + 2);
    // async reset with a beat stuck in the output register
    @(posedge clk); #1;
    phy_ready = 1'b0;
    drive(1'b0, {1'b0, 1'b0, 8'h5A}, 0, polls);
    a_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'({phy_valid, busy}), 32'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'({phy_valid, busy, a_ready}), 0);
    check("async_rst_data", 32'({owner, phy_rs, phy_data}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    phy_ready = 1'b1;
    sq.push_back({1'b1, 8'hC1}); sq.push_back({1'b1, 8'hC2}); sq.push_back({1'b0, 8'hD1});
    fork
      begin
        int pa;
        drive(1'b0, {1'b0, 1'b1, 8'hC1}, 0, pa);
        drive(1'b0, {1'b1, 1'b1, 8'hC2}, 0, pa);
        a_valid = 1'b0;
      end
      begin
        int pb;
        drive(1'b1, {1'b1, 1'b0, 8'hD1}, 0, pb);
        b_valid = 1'b0;
      end
    join
    for (int k = 0; k < 200 && (sq.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    check("final_drain", sq.size() + q1.size(), 0);
    check("err_pulses", err_pulses, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
